// File: rtl/systolic_array.sv
// Ifmap-stationary N x N MAC array: the ifmap tile is held in the PEs, weights move right
// and partial sums move down, both diagonally skewed by the caller.
module systolic_array #(
  parameter int PE_SIZE    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] ifmap_row_i,
  input  logic [DATA_WIDTH*PE_SIZE-1:0] weight_col_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
  input  logic                          ifmap_preload_i,
  input  logic [PE_SIZE-1:0]            weight_en_col_i,
  input  logic [PE_SIZE-1:0]            psum_en_row_i,
  output logic [DATA_WIDTH*PE_SIZE-1:0] ifmap_row_o,
  output logic [DATA_WIDTH*PE_SIZE-1:0] weight_col_o,
  output logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_o,
  output logic [PE_SIZE-1:0]            weight_en_col_o,
  output logic [PE_SIZE-1:0]            psum_en_row_o
);
  localparam int N  = PE_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int PW = PSUM_WIDTH;
  localparam int CW = $clog2(N) + 1;

  logic [CW-1:0] load_cnt_q, load_cnt_d;
  logic          load_s;

  logic [DW-1:0] ifmap_q  [N][N];
  logic [DW-1:0] ifmap_d  [N][N];
  logic [DW-1:0] weight_q [N][N];
  logic          wvld_q   [N][N];
  logic [PW-1:0] psum_q   [N][N];
  logic [PW-1:0] psum_d   [N][N];
  logic          pvld_q   [N][N];

  logic [DW-1:0]          ifmap_in_s [N][N];
  logic [DW-1:0]          w_in_s     [N][N];
  logic                   wv_in_s    [N][N];
  logic [PW-1:0]          psum_in_s  [N][N];
  logic                   pv_in_s    [N][N];
  logic signed [2*DW-1:0] prod_s     [N][N];
  logic [PW-1:0]          mac_s      [N][N];

  // The load window covers the preload edge plus the following N-1 edges; a new preload restarts it.
  always_comb begin
    load_s = ifmap_preload_i || (load_cnt_q != '0);
    if (ifmap_preload_i) begin
      load_cnt_d = CW'(N - 1);
    end else if (load_cnt_q != '0) begin
      load_cnt_d = load_cnt_q - CW'(1);
    end else begin
      load_cnt_d = load_cnt_q;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      if (c == 0) begin : g_left
        assign w_in_s[r][c]  = weight_col_i[(N-1-r)*DW +: DW];
        assign wv_in_s[r][c] = weight_en_col_i[N-1-r];
      end else begin : g_inner_w
        assign w_in_s[r][c]  = weight_q[r][c-1];
        assign wv_in_s[r][c] = wvld_q[r][c-1];
      end
      if (r == 0) begin : g_top
        assign psum_in_s[r][c]  = psum_row_i[(N-1-c)*PW +: PW];
        assign pv_in_s[r][c]    = psum_en_row_i[N-1-c];
        assign ifmap_in_s[r][c] = ifmap_row_i[(N-1-c)*DW +: DW];
      end else begin : g_inner_p
        assign psum_in_s[r][c]  = psum_q[r-1][c];
        assign pv_in_s[r][c]    = pvld_q[r-1][c];
        assign ifmap_in_s[r][c] = ifmap_q[r-1][c];
      end
      // Full-width signed product, sign-extended; the sum wraps modulo 2^PW.
      assign prod_s[r][c] = $signed(ifmap_q[r][c]) * $signed(w_in_s[r][c]);
      assign mac_s[r][c]  = psum_in_s[r][c] + {{(PW-2*DW){prod_s[r][c][2*DW-1]}}, prod_s[r][c]};
      assign psum_d[r][c] = pv_in_s[r][c] ? (wv_in_s[r][c] ? mac_s[r][c] : psum_in_s[r][c]) : '0;
      assign ifmap_d[r][c] = load_s ? ifmap_in_s[r][c] : ifmap_q[r][c];
    end
  end

  // PE state registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      load_cnt_q <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          ifmap_q[r][c]  <= '0;
          weight_q[r][c] <= '0;
          wvld_q[r][c]   <= 1'b0;
          psum_q[r][c]   <= '0;
          pvld_q[r][c]   <= 1'b0;
        end
      end
    end else begin
      load_cnt_q <= load_cnt_d;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          ifmap_q[r][c]  <= ifmap_d[r][c];
          weight_q[r][c] <= w_in_s[r][c];
          wvld_q[r][c]   <= wv_in_s[r][c];
          psum_q[r][c]   <= psum_d[r][c];
          pvld_q[r][c]   <= pv_in_s[r][c];
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign ifmap_row_o[(N-1-k)*DW +: DW]  = ifmap_q[N-1][k];
    assign weight_col_o[(N-1-k)*DW +: DW] = weight_q[k][N-1];
    assign weight_en_col_o[N-1-k]         = wvld_q[k][N-1];
    assign psum_row_o[(N-1-k)*PW +: PW]   = psum_q[N-1][k];
    assign psum_en_row_o[N-1-k]           = pvld_q[N-1][k];
  end

endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for systolic_array (N=4, 8-bit data, 32-bit psums).
module tb_systolic_array;
  logic         clk;
  logic         rst_n;
  logic [31:0]  ifmap_row_i;
  logic [31:0]  weight_col_i;
  logic [127:0] psum_row_i;
  logic         ifmap_preload_i;
  logic [3:0]   weight_en_col_i;
  logic [3:0]   psum_en_row_i;
  logic [31:0]  ifmap_row_o;
  logic [31:0]  weight_col_o;
  logic [127:0] psum_row_o;
  logic [3:0]   weight_en_col_o;
  logic [3:0]   psum_en_row_o;

  int errors_r;
  int checks_r;

  logic [3:0]   en_tab [8];
  logic [31:0]  w_tab  [8];
  logic [31:0]  res_tab [4];
  logic [127:0] exp_psum_s;
  logic [31:0]  exp_w_s;
  logic [3:0]   exp_pen_s;
  logic [3:0]   exp_wen_s;

  systolic_array #(.PE_SIZE(4), .DATA_WIDTH(8), .PSUM_WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ifmap_row_i     (ifmap_row_i),
    .weight_col_i    (weight_col_i),
    .psum_row_i      (psum_row_i),
    .ifmap_preload_i (ifmap_preload_i),
    .weight_en_col_i (weight_en_col_i),
    .psum_en_row_i   (psum_en_row_i),
    .ifmap_row_o     (ifmap_row_o),
    .weight_col_o    (weight_col_o),
    .psum_row_o      (psum_row_o),
    .weight_en_col_o (weight_en_col_o),
    .psum_en_row_o   (psum_en_row_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifmap_row_i     = 32'h0;
    weight_col_i    = 32'h0;
    psum_row_i      = 128'h0;
    ifmap_preload_i = 1'b0;
    weight_en_col_i = 4'b0000;
    psum_en_row_i   = 4'b0000;
  endtask

  initial begin
    errors_r = 0;
    checks_r = 0;
    en_tab  = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    w_tab   = '{32'h01000000, 32'h01020000, 32'h01020300, 32'h01020304,
                32'h00020304, 32'h00000304, 32'h00000004, 32'h00000000};
    res_tab = '{32'd19, 32'd15, 32'd15, 32'd13};

    // Reset with random inputs driven.
    rst_n           = 1'b1;
    ifmap_row_i     = $urandom;
    weight_col_i    = $urandom;
    psum_row_i      = {$urandom, $urandom, $urandom, $urandom};
    ifmap_preload_i = 1'b1;
    weight_en_col_i = 4'b1111;
    psum_en_row_i   = 4'b1111;
    #2;
    step();
    chk("rst_ifmap", {96'h0, ifmap_row_o}, 128'h0);
    chk("rst_wcol", {96'h0, weight_col_o}, 128'h0);
    chk("rst_psum", psum_row_o, 128'h0);
    chk("rst_wen", {124'h0, weight_en_col_o}, 128'h0);
    chk("rst_pen", {124'h0, psum_en_row_o}, 128'h0);
    rst_n = 1'b0;
    idle_inputs();

    // Preload: first row supplied ends in the bottom row.
    ifmap_preload_i = 1'b1;
    ifmap_row_i     = 32'h03020203;
    step();
    ifmap_preload_i = 1'b0;
    ifmap_row_i     = 32'h00010100;
    step();
    ifmap_row_i     = 32'h03020100;
    step();
    ifmap_row_i     = 32'h01000201;
    step();
    chk("preload_row3", {96'h0, ifmap_row_o}, {96'h0, 32'h03020203});
    ifmap_row_i     = 32'h10101010;
    step();
    chk("preload_hold", {96'h0, ifmap_row_o}, {96'h0, 32'h03020203});
    ifmap_row_i     = 32'h0;
    step();

    // Skewed MAC stream; W[r][k] = r+1 so every element of column c gives the same sum.
    for (int s = 0; s < 12; s++) begin
      if (s < 8) begin
        weight_en_col_i = en_tab[s];
        psum_en_row_i   = en_tab[s];
        weight_col_i    = w_tab[s];
      end else begin
        idle_inputs();
      end
      step();
      exp_psum_s = 128'h0;
      exp_pen_s  = 4'b0000;
      exp_w_s    = 32'h0;
      exp_wen_s  = 4'b0000;
      for (int c = 0; c < 4; c++) begin
        if ((s - 3 - c >= 0) && (s - 3 - c <= 3)) begin
          exp_pen_s[3-c]             = 1'b1;
          exp_psum_s[(3-c)*32 +: 32] = res_tab[c];
          exp_wen_s[3-c]             = 1'b1;
          exp_w_s[(3-c)*8 +: 8]      = 8'(c + 1);
        end
      end
      chk($sformatf("mac_psum_s%0d", s), psum_row_o, exp_psum_s);
      chk($sformatf("mac_pen_s%0d", s), {124'h0, psum_en_row_o}, {124'h0, exp_pen_s});
      chk($sformatf("mac_w_s%0d", s), {96'h0, weight_col_o}, {96'h0, exp_w_s});
      chk($sformatf("mac_wen_s%0d", s), {124'h0, weight_en_col_o}, {124'h0, exp_wen_s});
    end

    // Weights valid, psums invalid: no psum output, weights still pass through.
    weight_col_i    = 32'h05060708;
    weight_en_col_i = 4'b1111;
    psum_row_i      = {4{32'h11111111}};
    psum_en_row_i   = 4'b0000;
    step();
    idle_inputs();
    for (int s = 1; s < 4; s++) begin
      chk($sformatf("nopsum_p_s%0d", s), psum_row_o, 128'h0);
      chk($sformatf("nopsum_en_s%0d", s), {124'h0, psum_en_row_o}, 128'h0);
      step();
    end
    chk("nopsum_p_last", psum_row_o, 128'h0);
    chk("nopsum_w", {96'h0, weight_col_o}, {96'h0, 32'h05060708});
    chk("nopsum_wen", {124'h0, weight_en_col_o}, {124'h0, 4'b1111});

    // New tile: row0 = {-128, 1, 0, 0}, all other rows zero.
    ifmap_preload_i = 1'b1;
    step();
    ifmap_preload_i = 1'b0;
    step();
    step();
    ifmap_row_i = 32'h80010000;
    step();
    idle_inputs();
    step();
    // Element 0: -128*127 in column 0; element 1: 0x7FFFFFFF + 1*1 in column 1.
    weight_col_i    = 32'h7F000000;
    weight_en_col_i = 4'b1000;
    psum_en_row_i   = 4'b1000;
    step();
    weight_col_i    = 32'h01000000;
    weight_en_col_i = 4'b1000;
    psum_en_row_i   = 4'b0000;
    step();
    idle_inputs();
    psum_row_i      = {32'h0, 32'h7FFFFFFF, 64'h0};
    psum_en_row_i   = 4'b0100;
    step();
    idle_inputs();
    step();
    chk("signed_psum", psum_row_o, {32'hFFFFC080, 96'h0});
    chk("signed_pen", {124'h0, psum_en_row_o}, {124'h0, 4'b1000});
    step();
    step();
    chk("wrap_psum", psum_row_o, {32'h0, 32'h80000000, 64'h0});
    chk("wrap_pen", {124'h0, psum_en_row_o}, {124'h0, 4'b0100});

    // Preload restarted two edges into a window.
    ifmap_preload_i = 1'b1;
    ifmap_row_i     = 32'h11111111;
    step();
    ifmap_preload_i = 1'b0;
    ifmap_row_i     = 32'h22222222;
    step();
    ifmap_preload_i = 1'b1;
    ifmap_row_i     = 32'h33333333;
    step();
    ifmap_preload_i = 1'b0;
    ifmap_row_i     = 32'h44444444;
    step();
    chk("restart_mid_a", {96'h0, ifmap_row_o}, {96'h0, 32'h11111111});
    ifmap_row_i     = 32'h55555555;
    step();
    chk("restart_mid_b", {96'h0, ifmap_row_o}, {96'h0, 32'h22222222});
    ifmap_row_i     = 32'h66666666;
    step();
    chk("restart_final", {96'h0, ifmap_row_o}, {96'h0, 32'h33333333});
    ifmap_row_i     = 32'h77777777;
    step();
    chk("restart_hold", {96'h0, ifmap_row_o}, {96'h0, 32'h33333333});

    // Reset mid-preload cancels the window.
    ifmap_preload_i = 1'b1;
    ifmap_row_i     = 32'h99999999;
    step();
    ifmap_preload_i = 1'b0;
    rst_n           = 1'b1;
    step();
    rst_n           = 1'b0;
    chk("midrst_clear", {96'h0, ifmap_row_o}, 128'h0);
    ifmap_row_i     = 32'hAAAAAAAA;
    for (int s = 0; s < 4; s++) begin
      step();
    end
    chk("midrst_nowin", {96'h0, ifmap_row_o}, 128'h0);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
# systolic_array

Output-stationary-free, ifmap-stationary systolic array of PE_SIZE x PE_SIZE multiply-accumulate PEs. An ifmap tile is preloaded once and held in the PEs. Weights stream left-to-right along rows, and partial sums flow top-to-bottom along columns, both diagonally skewed. It sits between the on-chip ifmap/weight/psum buffers and the accumulator stage of the convolution datapath.

## Interface
- PE_SIZE, 4: array dimension N (rows = columns = N).
- DATA_WIDTH, 8: ifmap/weight element width, signed two's complement.
- PSUM_WIDTH, 32: partial-sum width, signed two's complement.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-high.
  - Name is kept for codebase compatibility.
  - Asserted (1) at a rising edge clears all state.
- ifmap_row_i  in  DATA_WIDTH*N  one ifmap row; lane c feeds column c.
- weight_col_i  in  DATA_WIDTH*N  one weight per array row; lane r feeds row r at the left edge.
- psum_row_i  in  PSUM_WIDTH*N  one psum per column; lane c feeds column c at the top edge.
- ifmap_preload_i  in  1  single-cycle start of an N-row ifmap load.
- weight_en_col_i  in  N  per-lane valid for weight_col_i.
- psum_en_row_i  in  N  per-lane valid for psum_row_i.
- ifmap_row_o  out  DATA_WIDTH*N  stored ifmap of bottom row N-1.
- weight_col_o  out  DATA_WIDTH*N  weights leaving the right edge (column N-1).
- psum_row_o  out  PSUM_WIDTH*N  psums leaving the bottom edge (row N-1).
- weight_en_col_o  out  N  valid for weight_col_o lanes.
- psum_en_row_o  out  N  valid for psum_row_o lanes.

Lane packing (all vectors): lane k occupies bits [(N-1-k)*W +: W]. Lane 0 is the most significant field and maps to row 0 (top) or column 0 (left).

## Operation
- Each PE[r][c] holds:
  - an ifmap register;
  - a registered weight + weight-valid, passed right;
  - a registered psum + psum-valid, passed down.
- Ifmap preload:
  - ifmap_preload_i=1 at edge t starts a load window covering edges t..t+N-1.
  - At each edge in the window, ifmap_row_i is written into row 0 and every row r shifts into row r+1.
  - The first row supplied therefore ends in row N-1; the N-th row supplied ends in row 0.
  - Outside the window, ifmap registers hold and ifmap_row_i is ignored.
  - Preload asserted inside an active window restarts the window at that edge.
- Weight flow:
  - PE[r][c] registers its weight and valid from its left neighbour (from weight_col_i lane r when c=0).
  - These registers update every edge, whether or not the valid is set.
- Psum flow and MAC:
  - PE[r][c] takes its upper input (psum_row_i lane c when r=0).
  - If psum-in valid and weight-in valid: registers psum_in + sext(ifmap[r][c] * weight_in), with valid=1.
  - If psum-in valid but weight invalid: registers psum_in unchanged, with valid=1.
  - If psum-in invalid: registers 0, with valid=0.
- Arithmetic:
  - The product is the full 2*DATA_WIDTH signed result, sign-extended to PSUM_WIDTH.
  - The sum wraps modulo 2^PSUM_WIDTH; no saturation.
- Caller skew requirement: weight lane r and psum lane c are presented r and c cycles late respectively. Weight stream element k of row r then meets psum element k of column c at PE[r][c].
- Result: psum_row_o lane c, element k = psum_in[k][c] + Σr ifmap[r][c]·W[r][k].
- Outputs are the bottom-row psum registers, the right-column weight registers, and row N-1 ifmap registers.

## Timing
- Reset: every register clears to 0, so every output is 0 and every valid is 0. The preload window is cancelled.
- Reset mid-preload or mid-stream: the array is fully cleared; the next preload starts fresh.
- Latency, input sampled at edge t:
  - PE[r][c] output is updated at edge t+r+c.
  - psum_row_o lane c (input at column c) is valid after edge t+N-1.
  - weight_col_o lane r is valid after edge t+N-1.
- The ifmap is usable by MACs from the edge after the last load edge (t+N).
- Streams may overlap the final load edge only at the caller's risk; no interlock is provided.
- Throughput: one weight vector and one psum vector per cycle, with no back-pressure.

## Test plan
- Reset: hold rst_n=1 for 1 edge with random inputs -> all outputs 0, all valids 0.
- Preload, N=4:
  - Stimulus: preload=1 with 0x03020203, then 0x00010100, 0x03020100, 0x01000201, then 0x10101010 and zeros.
  - Required: ifmap_row_o=0x03020203 after the 4th load edge, unchanged by the 0x10101010 row.
- Skewed MAC, after the above preload:
  - Stimulus: weight_en/psum_en = 1000,1100,1110,1111,0111,0011,0001,0000; weights 0x01000000,0x01020000,0x01020300,0x01020304,0x00020304,0x00000304,0x00000004; psum_in=0.
  - Required: each psum_row_o lane shows 4 valid results, column c lagging c cycles: col0=19, col1=15, col2=15, col3=13.
  - Required: weight_col_o replays 1,2,3,4 per lane with the same skew.
- psum_en=0 with weight_en=1: psum_en_row_o stays 0 and psum_row_o=0, while weights still propagate.
- Signed/wrap:
  - ifmap=0x80 (-128), weight=0x7F, psum_in=0 -> -16256.
  - psum_in=0x7FFFFFFF with product 1 -> 0x80000000.
- Preload re-asserted 2 cycles into a window -> the load restarts; the final rows are the last 4 supplied.
